// File: rtl/mvd_can_mv_buf_if.sv
// Port bundle for the candidate MV buffer: PU write, LCU-end handshake and
// the two candidate read ports.
`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 8
`endif

interface mvd_can_mv_buf_if #(
    parameter int MV_W = 20
);
    logic [`PIC_X_WIDTH-1:0] mb_x_i;
    logic                    wr_en_i;
    logic                    wr_ready_o;
    logic [5:0]              wr_pos_x_i;
    logic [5:0]              wr_pos_y_i;
    logic [6:0]              wr_width_i;
    logic [6:0]              wr_height_i;
    logic [MV_W-1:0]         wr_mv_i;
    logic                    lcu_done_i;
    logic                    copy_done_o;
    logic                    rd_en_i;
    logic [7:0]              a_addr_i;
    logic [8:0]              b_addr_i;
    logic [MV_W-1:0]         a_mv_o;
    logic                    a_valid_o;
    logic [MV_W-1:0]         b_mv_o;
    logic                    b_valid_o;

    modport master (
        output mb_x_i, wr_en_i, wr_pos_x_i, wr_pos_y_i, wr_width_i, wr_height_i,
               wr_mv_i, lcu_done_i, rd_en_i, a_addr_i, b_addr_i,
        input  wr_ready_o, copy_done_o, a_mv_o, a_valid_o, b_mv_o, b_valid_o
    );

    modport slave (
        input  mb_x_i, wr_en_i, wr_pos_x_i, wr_pos_y_i, wr_width_i, wr_height_i,
               wr_mv_i, lcu_done_i, rd_en_i, a_addr_i, b_addr_i,
        output wr_ready_o, copy_done_o, a_mv_o, a_valid_o, b_mv_o, b_valid_o
    );
endinterface

// File: rtl/mvd_can_mv_buf.sv
// Motion-vector store for merge/AMVP candidate fetch: current-LCU 8x8 grid,
// left column of the previous LCU and a frame-wide top line buffer.
//
// state | meaning
// IDLE  | accepting PU writes; launches edge copy on lcu_done or pending copy
// FILL  | writing one 8x8 unit of the latched PU per cycle, x fastest
// COPY  | 8 cycles copying right column to left[] and bottom row to top[]
`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 8
`endif

module mvd_can_mv_buf #(
    parameter int MV_W      = 20,
    parameter int MAX_LCU_X = 32,
    parameter int TOP_AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    mvd_can_mv_buf_if.slave bus
);
    localparam int PXW   = `PIC_X_WIDTH;
    localparam int TOP_D = MAX_LCU_X * 8;

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_COPY} state_t;

    state_t            state;
    logic              copy_pending;
    logic              wr_ready;
    logic              copy_done;
    logic [2:0]        x0, y0;
    logic [3:0]        nw, nh;
    logic [3:0]        fill_i, fill_j;
    logic [MV_W-1:0]   mv_q;
    logic [2:0]        copy_k;
    logic [PXW-1:0]    mb_x_lat;
    logic [PXW-1:0]    mb_x_q;

    logic [MV_W-1:0]   cur_mem  [0:63];
    logic [MV_W-1:0]   left_mem [0:7];
    logic [MV_W-1:0]   top_mem  [0:TOP_D-1];

    logic [4:0]        fill_x, fill_y;
    logic              fill_in_range;
    logic [TOP_AW-1:0] top_wr_addr, top_rd_addr;
    logic [3:0]        w_units, h_units;

    logic [1:0]        a_sel, b_sel;
    logic [2:0]        a_y, a_x, b_y;
    logic [3:0]        b_x;

    logic [MV_W-1:0]   a_mv, b_mv;
    logic              a_valid, b_valid;

    logic              unused_bits;
    assign unused_bits = ^{bus.wr_pos_x_i[2:0], bus.wr_pos_y_i[2:0],
                           bus.wr_width_i[2:0], bus.wr_height_i[2:0]};

    assign w_units = (bus.wr_width_i[6:3]  == 4'd0) ? 4'd1 : bus.wr_width_i[6:3];
    assign h_units = (bus.wr_height_i[6:3] == 4'd0) ? 4'd1 : bus.wr_height_i[6:3];

    // Units past the LCU edge still take a cycle, they just do not write.
    assign fill_x        = 5'(x0) + 5'(fill_i);
    assign fill_y        = 5'(y0) + 5'(fill_j);
    assign fill_in_range = (fill_x[4:3] == 2'b00) && (fill_y[4:3] == 2'b00);

    // mb_x_q is the LCU currently being processed: one past the last copied one.
    assign mb_x_q      = mb_x_lat + PXW'(1);
    assign top_wr_addr = TOP_AW'({mb_x_lat, 3'b000}) + TOP_AW'(copy_k);
    assign top_rd_addr = TOP_AW'({mb_x_q, 3'b000}) + TOP_AW'(b_x);

    assign a_sel = bus.a_addr_i[7:6];
    assign a_y   = bus.a_addr_i[5:3];
    assign a_x   = bus.a_addr_i[2:0];
    assign b_sel = bus.b_addr_i[8:7];
    assign b_y   = bus.b_addr_i[6:4];
    assign b_x   = bus.b_addr_i[3:0];

    // Sequencer: PU fill, deferred LCU-end request and edge copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            copy_pending <= 1'b0;
            wr_ready     <= 1'b1;
            copy_done    <= 1'b0;
            x0           <= '0;
            y0           <= '0;
            nw           <= 4'd1;
            nh           <= 4'd1;
            fill_i       <= '0;
            fill_j       <= '0;
            mv_q         <= '0;
            copy_k       <= '0;
            mb_x_lat     <= '0;
        end else begin
            copy_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.wr_en_i) begin
                        x0       <= bus.wr_pos_x_i[5:3];
                        y0       <= bus.wr_pos_y_i[5:3];
                        nw       <= w_units;
                        nh       <= h_units;
                        mv_q     <= bus.wr_mv_i;
                        fill_i   <= '0;
                        fill_j   <= '0;
                        wr_ready <= 1'b0;
                        state    <= ST_FILL;
                        if (bus.lcu_done_i) begin
                            copy_pending <= 1'b1;
                        end
                    end else if (bus.lcu_done_i || copy_pending) begin
                        mb_x_lat     <= bus.mb_x_i;
                        copy_pending <= 1'b0;
                        copy_k       <= '0;
                        wr_ready     <= 1'b0;
                        state        <= ST_COPY;
                    end
                end
                ST_FILL: begin
                    if (bus.lcu_done_i) begin
                        copy_pending <= 1'b1;
                    end
                    if (fill_i == nw - 4'd1) begin
                        fill_i <= '0;
                        if (fill_j == nh - 4'd1) begin
                            wr_ready <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            fill_j <= fill_j + 4'd1;
                        end
                    end else begin
                        fill_i <= fill_i + 4'd1;
                    end
                end
                ST_COPY: begin
                    copy_k <= copy_k + 3'd1;
                    if (copy_k == 3'd7) begin
                        wr_ready  <= 1'b1;
                        copy_done <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    wr_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage writes; memories survive reset, but no write lands while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_FILL && fill_in_range) begin
            cur_mem[{fill_y[2:0], fill_x[2:0]}] <= mv_q;
        end
        if (!rst && state == ST_COPY) begin
            top_mem[top_wr_addr] <= cur_mem[{3'd7, copy_k}];
            left_mem[copy_k]     <= cur_mem[{copy_k, 3'd7}];
        end
    end

    // Candidate lookup, registered; reads see pre-write contents on collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_mv    <= '0;
            a_valid <= 1'b0;
            b_mv    <= '0;
            b_valid <= 1'b0;
        end else if (bus.rd_en_i) begin
            case (a_sel)
                2'b10: begin
                    a_mv    <= cur_mem[{a_y, a_x}];
                    a_valid <= 1'b1;
                end
                2'b01: begin
                    a_mv    <= left_mem[a_y];
                    a_valid <= 1'b1;
                end
                default: begin
                    a_mv    <= '0;
                    a_valid <= 1'b0;
                end
            endcase
            case (b_sel)
                2'b10: begin
                    if (!b_x[3]) begin
                        b_mv    <= cur_mem[{b_y, b_x[2:0]}];
                        b_valid <= 1'b1;
                    end else begin
                        b_mv    <= '0;
                        b_valid <= 1'b0;
                    end
                end
                2'b01: begin
                    b_mv    <= top_mem[top_rd_addr];
                    b_valid <= 1'b1;
                end
                default: begin
                    b_mv    <= '0;
                    b_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_ready_o  = wr_ready;
    assign bus.copy_done_o = copy_done;
    assign bus.a_mv_o      = a_mv;
    assign bus.a_valid_o   = a_valid;
    assign bus.b_mv_o      = b_mv;
    assign bus.b_valid_o   = b_valid;
endmodule
